scan_state_gen: RTL and testbench

//  Parametrised prescaler plus state sequencer for display scan and time-multiplexing.

---
 rtl/scan_pkg.sv | 20 ++
 rtl/tick_div.sv | 35 +++
 rtl/scan_state_gen.sv | 107 ++++++++++
 tb/tb_scan_state_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and helpers for the display scan state generator.
// Default timing constants, count direction and load clamping.
package scan_pkg;

   localparam int unsigned DEF_DIV_MAX = 99_999;
   localparam int unsigned DEF_ST_MAX  = 7;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   function automatic int unsigned clamp_st(
      input int unsigned v,
      input int unsigned mx
   );
      return (v > mx) ? mx : v;
   endfunction

endpackage

// File: rtl/tick_div.sv
// Prescaler: pulses tick_o on the enabled cycle where the count
// reaches DIV_MAX, then restarts from zero.
module tick_div
   import scan_pkg::*;
#(
   parameter int unsigned DIV_MAX = DEF_DIV_MAX
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick_o
);

   localparam int unsigned DW_RAW = $clog2(DIV_MAX + 1);
   localparam int unsigned DW     = (DW_RAW < 1) ? 1 : DW_RAW;
   localparam logic [DW-1:0] DIV_TC = DW'(DIV_MAX);

   logic [DW-1:0] r_div;
   logic          w_tc;

   assign w_tc   = (r_div == DIV_TC);
   assign tick_o = en & ~clr & w_tc;

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_div <= '0;
      end else if (clr) begin
         r_div <= '0;
      end else if (en) begin
         r_div <= w_tc ? '0 : r_div + DW'(1);
      end
   end

endmodule

// File: rtl/scan_state_gen.sv
// Display scan sequencer: steps a state index on each prescaler tick,
// with up/down, wrap/one-shot, load/clear and a one-hot select decode.
module scan_state_gen
   import scan_pkg::*;
#(
   parameter int unsigned DIV_MAX     = DEF_DIV_MAX,
   parameter int unsigned ST_W        = 3,
   parameter int unsigned ST_MAX      = DEF_ST_MAX,
   parameter bit          SEL_ACT_LOW = 1'b1
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic              load,
   input  logic [ST_W-1:0]   load_val,
   input  logic              dir,
   input  logic              oneshot,
   output logic [ST_W-1:0]   st,
   output logic [ST_MAX:0]   sel,
   output logic              tick,
   output logic              wrap,
   output logic              done
);

   localparam logic [ST_W-1:0] ST_TOP = ST_W'(ST_MAX);

   logic [ST_W-1:0] r_st;
   logic            r_tick;
   logic            r_wrap;
   logic            r_done;
   logic            w_step;
   logic            w_div_clr;
   logic [ST_MAX:0] w_hot;
   logic [ST_W-1:0] w_ld;

   assign w_div_clr = clr | load | r_done;
   assign w_ld = ST_W'(clamp_st(32'(load_val), ST_MAX));

   tick_div #(
      .DIV_MAX (DIV_MAX)
   ) u_div (
      .sys_clk (sys_clk),
      .rst     (rst),
      .en      (en),
      .clr     (w_div_clr),
      .tick_o  (w_step)
   );

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_st   <= '0;
         r_tick <= 1'b0;
         r_wrap <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         r_wrap <= 1'b0;
         if (clr) begin
            r_st   <= '0;
            r_done <= 1'b0;
         end else if (load) begin
            r_st   <= w_ld;
            r_done <= 1'b0;
         end else if (w_step) begin
            r_tick <= 1'b1;
            if (dir == DIR_UP) begin
               if (r_st == ST_TOP) begin
                  if (oneshot) begin
                     r_done <= 1'b1;
                  end else begin
                     r_st   <= '0;
                     r_wrap <= 1'b1;
                  end
               end else begin
                  r_st <= r_st + ST_W'(1);
               end
            end else begin
               if (r_st == '0) begin
                  if (oneshot) begin
                     r_done <= 1'b1;
                  end else begin
                     r_st   <= ST_TOP;
                     r_wrap <= 1'b1;
                  end
               end else begin
                  r_st <= r_st - ST_W'(1);
               end
            end
         end
      end
   end

   always_comb begin
      w_hot = '0;
      for (int i = 0; i <= int'(ST_MAX); i++) begin
         w_hot[i] = (r_st == ST_W'(i));
      end
   end

   assign sel  = SEL_ACT_LOW ? ~w_hot : w_hot;
   assign st   = r_st;
   assign tick = r_tick;
   assign wrap = r_wrap;
   assign done = r_done;

endmodule

// File: tb/tb_scan_state_gen.sv
// Directed plus randomized bench for scan_state_gen against a
// cycle-count / modular-arithmetic reference model.
module tb_scan_state_gen;

   localparam int DIV = 3;
   localparam int SW  = 3;
   localparam int SM  = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic          clr = 1'b0;
   logic          load = 1'b0;
   logic [SW-1:0] load_val = '0;
   logic          dir = 1'b1;
   logic          oneshot = 1'b0;
   logic [SW-1:0] st;
   logic [SM:0]   sel;
   logic          tick;
   logic          wrap;
   logic          done;

   int total = 0;
   int bad = 0;

   int m_cnt, m_st, m_done, m_tick, m_wrap;

   scan_state_gen #(
      .DIV_MAX     (DIV),
      .ST_W        (SW),
      .ST_MAX      (SM),
      .SEL_ACT_LOW (1'b1)
   ) dut (
      .sys_clk  (clk),
      .rst      (rst),
      .en       (en),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .dir      (dir),
      .oneshot  (oneshot),
      .st       (st),
      .sel      (sel),
      .tick     (tick),
      .wrap     (wrap),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic m_reset();
      m_cnt = 0; m_st = 0; m_done = 0; m_tick = 0; m_wrap = 0;
   endtask

   // Behaviour at one clock edge: count enabled cycles, step the
   // state modulo ST_MAX+1 every DIV+1 of them.
   task automatic m_edge();
      int lv;
      if (rst) begin
         m_reset();
         return;
      end
      m_tick = 0;
      m_wrap = 0;
      if (clr) begin
         m_cnt = 0; m_st = 0; m_done = 0;
      end else if (load) begin
         lv = int'(load_val);
         m_st = (lv > SM) ? SM : lv;
         m_cnt = 0; m_done = 0;
      end else if (en && m_done == 0) begin
         m_cnt++;
         if (m_cnt == DIV + 1) begin
            m_cnt = 0;
            m_tick = 1;
            if (dir) begin
               if (m_st == SM) begin
                  if (oneshot) m_done = 1;
                  else begin m_st = 0; m_wrap = 1; end
               end else m_st = m_st + 1;
            end else begin
               if (m_st == 0) begin
                  if (oneshot) m_done = 1;
                  else begin m_st = SM; m_wrap = 1; end
               end else m_st = m_st - 1;
            end
         end
      end
   endtask

   task automatic chk(input string tag);
      logic [SM:0] e_sel;
      e_sel = ~(6'd1 << m_st);
      total++;
      assert (st === SW'(m_st)) else begin
         bad++;
         $error("FAIL %s st obs=%0d exp=%0d", tag, st, m_st);
      end
      total++;
      assert (tick === 1'(m_tick)) else begin
         bad++;
         $error("FAIL %s tick obs=%0b exp=%0d", tag, tick, m_tick);
      end
      total++;
      assert (wrap === 1'(m_wrap)) else begin
         bad++;
         $error("FAIL %s wrap obs=%0b exp=%0d", tag, wrap, m_wrap);
      end
      total++;
      assert (done === 1'(m_done)) else begin
         bad++;
         $error("FAIL %s done obs=%0b exp=%0d", tag, done, m_done);
      end
      total++;
      assert (sel === e_sel) else begin
         bad++;
         $error("FAIL %s sel obs=%b exp=%b", tag, sel, e_sel);
      end
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      m_edge();
      #1;
      chk(tag);
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) cyc(tag);
   endtask

   initial begin
      m_reset();
      // 1: reset, count up with wrap
      #2;
      rst = 1'b1;
      #1;
      chk("reset");
      total++;
      assert (sel === 6'b111110) else begin
         bad++;
         $error("FAIL reset_sel obs=%b exp=111110", sel);
      end
      cyc("reset_hold");
      rst = 1'b0; en = 1'b1; dir = 1'b1; oneshot = 1'b0;
      run(30, "up_wrap");

      // 2: count down from 0 with wrap
      clr = 1'b1;
      cyc("clr");
      clr = 1'b0; dir = 1'b0;
      run(28, "down_wrap");

      // 3: one-shot from 4
      oneshot = 1'b1; dir = 1'b1; load = 1'b1; load_val = 3'd4;
      cyc("os_load");
      load = 1'b0;
      run(8, "os_step");
      total++;
      assert (done === 1'b1 && st === 3'd5) else begin
         bad++;
         $error("FAIL os_term obs=%0b/%0d exp=1/5", done, st);
      end
      run(20, "os_idle");
      oneshot = 1'b0;
      run(4, "os_sticky");
      load = 1'b1; load_val = 3'd1;
      cyc("os_reload");
      load = 1'b0;
      total++;
      assert (done === 1'b0) else begin
         bad++;
         $error("FAIL os_clear obs=%0b exp=0", done);
      end

      // 4: en low at div=2
      clr = 1'b1;
      cyc("hold_clr");
      clr = 1'b0;
      run(2, "hold_pre");
      en = 1'b0;
      run(10, "hold_off");
      en = 1'b1;
      cyc("hold_res1");
      cyc("hold_res2");
      total++;
      assert (tick === 1'b1 && st === 3'd1) else begin
         bad++;
         $error("FAIL hold_tick obs=%0b/%0d exp=1/1", tick, st);
      end

      // 5: clr beats load, load clamps
      clr = 1'b1; load = 1'b1; load_val = 3'd3;
      cyc("clr_load");
      clr = 1'b0; load_val = 3'd7;
      cyc("clamp");
      load = 1'b0;
      total++;
      assert (st === 3'd5) else begin
         bad++;
         $error("FAIL clamp_st obs=%0d exp=5", st);
      end

      // 6: async reset mid-interval at st=3
      clr = 1'b1;
      cyc("pre_rst");
      clr = 1'b0;
      run(14, "to_st3");
      #2;
      rst = 1'b1;
      #1;
      m_reset();
      chk("async_rst");
      cyc("rst_hold");
      rst = 1'b0;

      // random stress
      for (int i = 0; i < 400; i++) begin
         en       = ($urandom_range(0, 9) < 8);
         clr      = ($urandom_range(0, 39) == 0);
         load     = ($urandom_range(0, 24) == 0);
         load_val = SW'($urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0) dir = ~dir;
         if ($urandom_range(0, 19) == 0) oneshot = ~oneshot;
         cyc("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
